// File: rtl/bexkat_bus_pkg.sv
// Shared types and helpers for the byte-lane bus target: FSM states,
// lane identifiers and the lane-to-byte-offset mapping (big-endian).
package bexkat_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } bus_state_t;

    // Lane 3 carries dat[31:24], which is byte offset 0 within the word.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    function automatic logic [1:0] byte_offset(input logic [1:0] lane);
        return 2'd3 - lane;
    endfunction

endpackage

// File: rtl/lane_select.sv
// Priority encoder over the pending byte-lane mask: picks the highest set
// lane so bytes are issued in ascending byte-address order.
module lane_select
    import bexkat_bus_pkg::*;
(
    input  logic [3:0] mask,
    output logic [1:0] lane,
    output logic       none
);

    always_comb begin
        lane = LANE_B0;
        none = 1'b0;
        if (mask[3]) begin
            lane = LANE_B3;
        end else if (mask[2]) begin
            lane = LANE_B2;
        end else if (mask[1]) begin
            lane = LANE_B1;
        end else if (mask[0]) begin
            lane = LANE_B0;
        end else begin
            none = 1'b1;
        end
    end

endmodule

// File: rtl/bus_byte_target.sv
// 32-bit bus responder that serialises selected byte lanes onto an 8-bit port.
// Optional macro BUS_TIMEOUT_EN adds a mem_ready watchdog that ends in err_o.
module bus_byte_target
    import bexkat_bus_pkg::*;
#(
    parameter int AW      = 15,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic [AW-1:0] adr_i,
    input  logic [3:0]    sel_i,
    input  logic [31:0]   dat_i,
    output logic [31:0]   dat_o,
    output logic          ack_o,
    output logic          err_o,
    output logic [AW+1:0] mem_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ready
);

    bus_state_t    state;
    bus_state_t    state_n;
    logic [AW-1:0] adr_q;
    logic          we_q;
    logic [31:0]   dat_q;
    logic [3:0]    pend;
    logic          aborted;

    logic [1:0]    lane;
    logic          lane_none;
    logic [3:0]    lane_bit;
    logic [3:0]    pend_left;
    logic          accept;
    logic          handshake;
    logic          stop;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             timeout_hit;
`endif

    lane_select u_lane_select (
        .mask (pend),
        .lane (lane),
        .none (lane_none)
    );

    assign accept    = (state == IDLE) && cyc_i && stb_i;
    assign mem_req   = (state == XFER) && !lane_none;
    assign handshake = mem_req && mem_ready;
    assign lane_bit  = 4'b0001 << lane;
    assign pend_left = pend & ~lane_bit;
    // A dropped cyc_i is remembered so the in-flight byte can finish first.
    assign stop      = aborted || !cyc_i;

    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? {adr_q, byte_offset(lane)} : '0;
    assign mem_wdata = mem_req ? dat_q[{lane, 3'b000} +: 8] : '0;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (sel_i == '0) ? ACK : XFER;
                end
            end
            XFER: begin
                if (lane_none) begin
                    state_n = stop ? IDLE : ACK;
                end else if (handshake) begin
                    if (stop) begin
                        state_n = IDLE;
                    end else if (pend_left == '0) begin
                        state_n = ACK;
                    end
                end
`ifdef BUS_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_n = stop ? IDLE : ACK;
                end
`endif
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            pend    <= '0;
            aborted <= 1'b0;
            dat_o   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                adr_q   <= adr_i;
                we_q    <= we_i;
                dat_q   <= dat_i;
                pend    <= sel_i;
                aborted <= 1'b0;
                dat_o   <= '0;
            end
            if (state == XFER) begin
                aborted <= stop;
            end
            if (handshake) begin
                pend <= pend_left;
                if (!we_q) begin
                    dat_o[{lane, 3'b000} +: 8] <= mem_rdata;
                end
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Fires on the waiting cycle whose increment would bring the count to TIMEOUT.
    assign timeout_hit = mem_req && !mem_ready &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit && !stop;
            if (accept || handshake) begin
                wait_cnt <= '0;
            end else if (state == XFER) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // The termination cycle reuses ACK; err_q selects which strobe it shows.
    assign ack_o = (state == ACK) && !err_q;
    assign err_o = (state == ACK) && err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign ack_o = (state == ACK);
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_byte_target.sv
// Randomised scoreboard bench for bus_byte_target with a byte-memory device model.
module tb_bus_byte_target;

    localparam int AW         = 15;
    localparam int BW         = AW + 2;
    localparam int TB_TIMEOUT = 4;
    localparam int BUDGET     = 2000;

    typedef struct {
        logic [BW-1:0] addr;
        bit            we;
        logic [7:0]    wdata;
    } acc_t;

    typedef struct {
        bit          err;
        logic [31:0] data;
    } resp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cyc_i;
    logic          stb_i;
    logic          we_i;
    logic [AW-1:0] adr_i;
    logic [3:0]    sel_i;
    logic [31:0]   dat_i;
    logic [31:0]   dat_o;
    logic          ack_o;
    logic          err_o;
    logic [BW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;
    logic          mem_ready = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] dev_mem [0:(1<<BW)-1];
    logic [7:0] ref_mem [0:(1<<BW)-1];
    acc_t  acc_q[$];
    resp_t resp_q[$];
    int    fixed_wait = 0;

    bus_byte_target #(
        .AW      (AW),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .sel_i     (sel_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Device model: random or fixed ready delay, checks access order and stability.
    bit            busy = 0;
    int            wait_left = 0;
    logic [BW-1:0] s_addr;
    logic          s_we;
    logic [7:0]    s_wdata;

    always @(negedge clk_i) begin
        acc_t a;
        if (!mem_req || rst_i) begin
            busy      = 0;
            mem_ready = 1'b0;
        end else begin
            if (!busy) begin
                busy      = 1;
                wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                s_addr    = mem_addr;
                s_we      = mem_we;
                s_wdata   = mem_wdata;
            end else begin
                check("req_stable", {15'd0, mem_addr, mem_we, mem_wdata},
                      {15'd0, s_addr, s_we, s_wdata});
            end
            if (wait_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = dev_mem[mem_addr];
                busy      = 0;
                if (acc_q.size() == 0) begin
                    check("unexpected_access", {15'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    a = acc_q.pop_front();
                    check("access_addr", {15'd0, mem_addr}, {15'd0, a.addr});
                    check("access_we", {31'd0, mem_we}, {31'd0, a.we});
                    if (a.we) check("access_wdata", {24'd0, mem_wdata}, {24'd0, a.wdata});
                end
                if (mem_we) dev_mem[mem_addr] = mem_wdata;
            end else begin
                wait_left--;
                mem_ready = 1'b0;
                mem_rdata = 8'($urandom);
            end
        end
    end

    // Monitor: every termination is matched against the scoreboard queue.
    always @(negedge clk_i) begin
        resp_t r;
        if (!rst_i && (ack_o || err_o)) begin
            if (resp_q.size() == 0) begin
                check("unexpected_term", {30'd0, ack_o, err_o}, 32'd0);
            end else begin
                r = resp_q.pop_front();
                check("term_kind", {30'd0, ack_o, err_o}, r.err ? 32'd1 : 32'd2);
                if (!r.err) check("read_data", dat_o, r.data);
            end
        end
    end

    task automatic run_txn(input bit we, input logic [AW-1:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input int exp_lat, input bit exp_err);
        resp_t r;
        acc_t  a;
        int    c;
        int    ba;
        r.err  = exp_err;
        r.data = '0;
        if (!exp_err) begin
            for (int l = 3; l >= 0; l--) begin
                if (sel[l]) begin
                    ba      = int'(adr) * 4 + (3 - l);
                    a.addr  = BW'(ba);
                    a.we    = we;
                    a.wdata = dat[l*8 +: 8];
                    acc_q.push_back(a);
                    if (we) ref_mem[ba] = dat[l*8 +: 8];
                    else    r.data[l*8 +: 8] = ref_mem[ba];
                end
            end
        end
        resp_q.push_back(r);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        c = 0;
        do begin
            @(negedge clk_i);
            c++;
        end while (!(ack_o || err_o) && c < BUDGET);
        if (!(ack_o || err_o)) begin
            vectors++;
            miscompares++;
            $display("FAIL term_wait: no termination after %0d cycles, expected one", c);
        end else begin
            if (exp_lat > 0) check("latency", c, exp_lat);
            if (exp_err) check("err_req_low", {31'd0, mem_req}, 32'd0);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    initial begin
        acc_t a;
        for (int i = 0; i < (1 << BW); i++) begin
            dev_mem[i] = 8'(i * 29 + 7);
            ref_mem[i] = dev_mem[i];
        end
        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = '0; sel_i = '0; dat_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_req", {30'd0, mem_req, mem_we}, 32'd0);
        check("rst_addr_wdata", {7'd0, mem_addr, mem_wdata}, 32'd0);
        check("rst_dat_o", dat_o, 32'd0);
        rst_i = 1'b0;

        // Burst read of a known word, ready tied high.
        fixed_wait = 0;
        dev_mem['h40] = 8'h12; dev_mem['h41] = 8'h34; dev_mem['h42] = 8'h56; dev_mem['h43] = 8'h78;
        ref_mem['h40] = 8'h12; ref_mem['h41] = 8'h34; ref_mem['h42] = 8'h56; ref_mem['h43] = 8'h78;
        run_txn(1'b0, 15'h10, 4'b1111, 32'h0, 5, 1'b0);

        // Single-lane write.
        run_txn(1'b1, 15'h2, 4'b0010, 32'hAABBCCDD, 2, 1'b0);
        check("write_landed", {24'd0, dev_mem['h0A]}, 32'h0000_00CC);

        // Non-contiguous lanes with a slow device.
        fixed_wait = 3;
        run_txn(1'b0, 15'h5, 4'b1001, 32'h0, 9, 1'b0);

        // Empty select.
        fixed_wait = 0;
        run_txn(1'b0, 15'h3, 4'b0000, 32'h0, 1, 1'b0);

        // cyc_i dropped during the first byte: that byte finishes, nothing more.
        a.addr = BW'(6 * 4); a.we = 1'b0; a.wdata = 8'h00;
        acc_q.push_back(a);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 15'h6; sel_i = 4'b1111;
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("abort_req_low", {31'd0, mem_req}, 32'd0);
        check("abort_acc_left", acc_q.size(), 32'd0);

        // Reset in the middle of a waiting byte.
        fixed_wait = 3;
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 15'h7; sel_i = 4'b1111;
        @(negedge clk_i);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_ack", {31'd0, ack_o}, 32'd0);
        check("rst_mid_dat", dat_o, 32'd0);
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        repeat (2) @(negedge clk_i);

`ifdef BUS_TIMEOUT_EN
        fixed_wait = 1000000;
        run_txn(1'b0, 15'h4, 4'b1111, 32'h0, TB_TIMEOUT + 1, 1'b1);
        fixed_wait = 0;
        run_txn(1'b0, 15'h4, 4'b1111, 32'h0, 5, 1'b0);
`endif

        for (int i = 0; i < 160; i++) begin
            logic [3:0] sel;
            int lat;
            sel = 4'($urandom);
            fixed_wait = (i % 4 == 0) ? 0 : -1;
            lat = (fixed_wait == 0) ? ($countones(sel) + 1) : 0;
            run_txn(1'($urandom), AW'($urandom_range(0, 7)), sel, $urandom, lat, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        repeat (4) @(negedge clk_i);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("acc_q_drained", acc_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_byte_target.md
Name: bus_byte_target

Overview:
- Wishbone-style 32-bit bus responder with byte-lane selects that fronts an 8-bit peripheral/memory port.
- Splits each selected byte lane into one sequential 8-bit access in ascending byte-address order (big-endian: lane 3 = dat[31:24] = byte offset 0).
- On reads, packs the returned bytes back into their lanes on dat_o.
- Sits between the system bus and narrow devices such as the boot ROM, UART buffers and LCD RAM.

Parameters:
- AW, 15, word address width of adr_i.
- TIMEOUT, 255, maximum cycles to wait for mem_ready; only used when BUS_TIMEOUT_EN is defined.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous active-high reset
- cyc_i  input  1  bus cycle valid
- stb_i  input  1  strobe
- we_i  input  1  1 = write
- adr_i  input  AW  word address
- sel_i  input  4  byte-lane select
- dat_i  input  32  write data, lane-aligned
- dat_o  output  32  read data, lane-aligned; unselected lanes 0
- ack_o  output  1  one-cycle termination
- err_o  output  1  error termination (timeout only)
- mem_addr  output  AW+2  byte address = {adr, 2'(3-lane)}
- mem_req  output  1  byte access request
- mem_we  output  1  byte write enable, valid with mem_req
- mem_wdata  output  8  write byte
- mem_rdata  input  8  read byte, valid when mem_req & mem_ready
- mem_ready  input  1  byte access completes this cycle

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous, active-high.
- Reset values: state IDLE; ack_o=0, err_o=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dat_o=0. A reset mid-transaction abandons it with no ack.
- States: IDLE, XFER, ACK.
- IDLE:
  - If cyc_i & stb_i, latch adr_i, we_i, dat_i and sel_i into a pending mask; clear dat_o; go to XFER.
  - If sel_i == 0, go directly to ACK.
- XFER:
  - The current lane is the highest set bit of the pending mask.
  - mem_req=1, mem_we=latched we, mem_addr={adr, 3-lane}, mem_wdata=latched dat byte of that lane.
  - These outputs are stable until mem_ready.
  - On a cycle with mem_req & mem_ready:
    - clear the pending bit;
    - on a read, store mem_rdata into that lane of dat_o.
  - When the pending mask becomes 0, go to ACK.
- ACK: ack_o=1 for exactly one cycle; dat_o holds the read data that cycle; then IDLE.
- Latency:
  - Acceptance edge, then one cycle minimum per selected byte (more if mem_ready is delayed), then the ack cycle.
  - Example: sel=1111 with mem_ready tied high gives ack_o in the 5th cycle after acceptance.
- Non-contiguous sel values (e.g. 1001) are legal: exactly the set lanes are accessed, in order 3→0.
- cyc_i deassert during XFER: the current byte handshake still completes; no further bytes are issued; return to IDLE with no ack.
- stb_i is ignored outside IDLE.
- A new request is never accepted in the ACK cycle; the earliest acceptance is the following IDLE cycle.
- mem_req is never asserted in IDLE or ACK.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on each byte handshake and on entry to XFER, and increments each XFER cycle without mem_ready.
  - When the counter reaches TIMEOUT, drop mem_req, pulse err_o for one cycle (ack_o stays 0), discard the remaining lanes and return to IDLE.
- Undefined: the block waits indefinitely; err_o is tied 0; no counter is instantiated.

Decomposition:
- Shared package bexkat_bus_pkg holds:
  - state typedef enum {IDLE, XFER, ACK};
  - lane constants LANE_B0..LANE_B3;
  - the function byte_offset(lane)=3-lane.
- One sub-module, lane_select: combinational priority encoder taking the 4-bit pending mask and producing the 2-bit lane index plus a none flag.

Test Plan:
- Read, sel=1111, adr=0x10, mem_ready=1, device bytes at 0x40..0x43 = 12,34,56,78 → mem_addr 0x40,0x41,0x42,0x43 in order; ack_o once; dat_o=0x12345678.
- Write, sel=0010, dat_i=0xAABBCCDD, adr=0x2 → single mem_req at mem_addr 0x0A with mem_wdata=0xCC and mem_we=1; ack 2 cycles after acceptance.
- Read, sel=1001, mem_ready low 3 cycles per byte → addresses offset 0 then 3; mem_req held stable while waiting; dat_o=0xXX0000YY with the middle lanes 0.
- Request with sel=0000 → no mem_req; ack_o in the cycle after acceptance; dat_o=0.
- Abort and reset: drop cyc_i after the first byte of sel=1111 → no ack and IDLE; separately, assert rst_i in XFER → mem_req=0 at the next edge and no ack.
- BUS_TIMEOUT_EN with TIMEOUT=4 and mem_ready held 0 → err_o pulses 4 XFER cycles after entry; ack_o never asserts; the next request is serviced normally.
